// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory target: accepts one MemRead/MemWrite request, waits
// WAIT_CYCLES, then commits it and pulses mem_ready (with mem_error on rejection).
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_error
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        rd_reg;
    logic        wr_reg;
    logic [31:0] read_data_reg;
    logic        mem_ready_reg;
    logic        mem_error_reg;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic          req_error;
    logic [AW-1:0] word_idx;

    assign accept   = (state_reg == IDLE) && (mem_read || mem_write);
    // Commit happens on the BUSY edge that finds the counter already at zero.
    assign commit   = (state_reg == BUSY) && (cnt_reg == 4'd0);
    assign word_idx = addr_reg[AW+1:2];
    assign req_error = (addr_reg[1:0] != 2'b00) ||
                       (addr_reg[31:AW+2] != '0) ||
                       (rd_reg && wr_reg);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                    cnt_next   = WAIT_CYCLES[3:0];
                end
            end
            BUSY: begin
                if (commit) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            read_data_reg <= 32'd0;
            mem_ready_reg <= 1'b0;
            mem_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mem_ready_reg <= commit;
            mem_error_reg <= commit && req_error;
            if (commit) begin
                if (req_error) begin
                    read_data_reg <= 32'd0;
                end else if (rd_reg) begin
                    read_data_reg <= mem[word_idx];
                end
            end
        end
    end

    // Request capture and array write carry no reset; the array is never cleared.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            addr_reg  <= addr;
            wdata_reg <= write_data;
            rd_reg    <= mem_read;
            wr_reg    <= mem_write;
        end
        if (commit && wr_reg && !req_error && !rst) begin
            mem[word_idx] <= wdata_reg;
        end
    end

    assign read_data = read_data_reg;
    assign mem_ready = mem_ready_reg;
    assign mem_error = mem_error_reg;
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with two wait states,
// one with none for the back-to-back cadence.
module tb_data_memory_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, a_err, b_ready, b_err;

    int checks = 0;
    int errors = 0;

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .mem_read(a_rd), .mem_write(a_wr), .addr(a_addr),
        .write_data(a_wdata), .read_data(a_rdata), .mem_ready(a_ready), .mem_error(a_err));

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .mem_read(b_rd), .mem_write(b_wr), .addr(b_addr),
        .write_data(b_wdata), .read_data(b_rdata), .mem_ready(b_ready), .mem_error(b_err));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance a (sel=0) or b (sel=1); returns cycles to mem_ready.
    task automatic txn(input bit sel, input logic rd, input logic wr, input logic [31:0] ad,
                       input logic [31:0] wd, output int lat, output logic [31:0] rdat,
                       output logic err);
        logic rdy;
        lat = 0; rdat = '0; err = 1'b0; rdy = 1'b0;
        if (sel) begin b_rd = rd; b_wr = wr; b_addr = ad; b_wdata = wd; end
        else     begin a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd; end
        while (!rdy && lat < 30) begin
            @(posedge clk); #1;
            lat++;
            rdy  = sel ? b_ready : a_ready;
            rdat = sel ? b_rdata : a_rdata;
            err  = sel ? b_err : a_err;
        end
        if (sel) begin b_rd = 0; b_wr = 0; end
        else     begin a_rd = 0; a_wr = 0; end
        if (!rdy) lat = -1;
        $display("txn inst=%0d rd=%0b wr=%0b addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b",
                 sel, rd, wr, ad, wd, lat, rdat, err);
        @(posedge clk); #1;
    endtask

    int          lat;
    logic [31:0] rdat;
    logic        err;
    int          pulses;
    int          pc [4];
    logic [31:0] pd [4];
    logic        pe [4];

    initial begin
        rst = 1'b1;
        a_rd = 1; a_wr = 0; a_addr = 32'h10; a_wdata = 0;
        b_rd = 1; b_wr = 0; b_addr = 32'h10; b_wdata = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_ready", {31'd0, a_ready}, 32'd0);
            check("rst_error", {31'd0, a_err}, 32'd0);
            check("rst_rdata", a_rdata, 32'd0);
        end
        rst = 1'b0; a_rd = 0; b_rd = 0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_ready || b_ready) pulses++;
        end
        check("rst_no_response", pulses, 0);

        txn(0, 0, 1, 32'h10, 32'hDEADBEEF, lat, rdat, err);
        check("wr_latency", lat, 4);
        check("wr_error", {31'd0, err}, 32'd0);
        txn(0, 1, 0, 32'h10, 32'h0, lat, rdat, err);
        check("rd_latency", lat, 4);
        check("rd_data", rdat, 32'hDEADBEEF);
        check("rd_error", {31'd0, err}, 32'd0);

        txn(0, 0, 1, 32'h8, 32'h00000077, lat, rdat, err);
        check("wr_holds_rdata", rdat, 32'hDEADBEEF);

        txn(0, 1, 0, 32'h13, 32'h0, lat, rdat, err);
        check("misalign_error", {31'd0, err}, 32'd1);
        check("misalign_rdata", rdat, 32'd0);
        check("misalign_latency", lat, 4);
        txn(0, 1, 0, 32'h10, 32'h0, lat, rdat, err);
        check("after_misalign_rd", rdat, 32'hDEADBEEF);

        txn(0, 0, 1, 32'h0, 32'hCAFE0000, lat, rdat, err);
        txn(0, 0, 1, 32'h400, 32'h1, lat, rdat, err);
        check("range_error", {31'd0, err}, 32'd1);
        txn(0, 1, 0, 32'h0, 32'h0, lat, rdat, err);
        check("range_no_write", rdat, 32'hCAFE0000);
        check("range_rd_error", {31'd0, err}, 32'd0);

        txn(0, 1, 1, 32'h10, 32'h5, lat, rdat, err);
        check("conflict_error", {31'd0, err}, 32'd1);
        check("conflict_rdata", rdat, 32'd0);
        txn(0, 1, 0, 32'h10, 32'h0, lat, rdat, err);
        check("conflict_no_write", rdat, 32'hDEADBEEF);

        txn(0, 0, 1, 32'h20, 32'h11111111, lat, rdat, err);
        a_wr = 1; a_addr = 32'h20; a_wdata = 32'h22222222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; a_wr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_ready) pulses++;
        end
        check("abort_no_ready", pulses, 0);
        txn(0, 1, 0, 32'h20, 32'h0, lat, rdat, err);
        check("abort_no_write", rdat, 32'h11111111);

        txn(1, 0, 1, 32'h0, 32'hA0A0A0A0, lat, rdat, err);
        check("w0_wr_latency", lat, 2);
        txn(1, 0, 1, 32'h4, 32'hB4B4B4B4, lat, rdat, err);
        txn(1, 1, 0, 32'h8, 32'h0, lat, rdat, err);
        b_rd = 1; b_addr = 32'h0;
        pulses = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            if (b_ready && pulses < 4) begin
                pc[pulses] = cyc; pd[pulses] = b_rdata; pe[pulses] = b_err;
                pulses++;
                if (pulses == 2) b_addr = 32'h4;
            end
        end
        b_rd = 0;
        check("b2b_pulse_count", pulses, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < pulses) begin
                $display("b2b pulse %0d cycle=%0d rdata=%h err=%0b", k, pc[k], pd[k], pe[k]);
                check($sformatf("b2b_cycle%0d", k), pc[k], 2 + 3 * k);
                check($sformatf("b2b_data%0d", k), pd[k], (k < 2) ? 32'hA0A0A0A0 : 32'hB4B4B4B4);
                check($sformatf("b2b_err%0d", k), {31'd0, pe[k]}, 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
